id_ex_hazard_reg: RTL and testbench
===================================

Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection. It sits directly downstream of the Control decoder.
- Captures the 8-bit control word, operands and register indices from ID and presents them to EX one cycle later.
- Detects a load-use dependency between the held EX entry and the incoming ID instruction. On a hit it inserts a bubble and asserts a stall to the PC and IF/ID register.
- Handles branch/jump flush and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, operand and immediate width.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ctrl_i  in  8  control word from Control: [0] ALUSrc, [2:1] ALUOp, [3] RegDst, [4] MemRead, [5] MemWrite, [6] RegWrite, [7] MemtoReg.
- rs_data_i  in  DATA_W  register-file rs read data.
- rt_data_i  in  DATA_W  register-file rt read data.
- imm_i  in  DATA_W  sign-extended immediate.
- rs_addr_i  in  5  rs index of the ID instruction.
- rt_addr_i  in  5  rt index of the ID instruction.
- rd_addr_i  in  5  rd index of the ID instruction.
- flush_i  in  1  taken branch/jump; the ID instruction must be discarded.
- stall_o  out  1  combinational; hold the PC and IF/ID this cycle.
- ctrl_o  out  8  registered control word to EX.
- rs_data_o, rt_data_o, imm_o  out  DATA_W  registered operands.
- rs_addr_o, rt_addr_o, rd_addr_o  out  5  registered indices.
- valid_o  out  1  the EX entry holds a real instruction.
- stall_cnt_o  out  CNT_W  total bubble cycles inserted by hazards.

Behaviour:
- Reset (async, rst_i=1): every registered output is 0, including ctrl_o, all data and address outputs, valid_o and stall_cnt_o. stall_o is therefore 0.
- Latency: an instruction presented in cycle N appears on the outputs after edge N+1.
- Operand use, decided from ctrl_i:
  - rs is used whenever rs_addr_i != 0.
  - rt is used when rt_addr_i != 0 and (ctrl_i[0]==0 or ctrl_i[5]==1); sw uses rt as store data.
- hazard = valid_o & ctrl_o[4] & ctrl_o[6] & (rt_addr_o != 0) & ((rs used & rs_addr_i == rt_addr_o) | (rt used & rt_addr_i == rt_addr_o)).
- stall_o = hazard & ~flush_i. It is purely combinational from the current inputs and state.
- Edge update priority, highest first:
  1. flush_i=1: ctrl_o <= 0, valid_o <= 0. Data and address fields hold their values. The counter does not increment.
  2. hazard=1: bubble; ctrl_o <= 0, valid_o <= 0. Data and address fields hold. stall_cnt_o increments by 1, saturating at all-ones (no wrap).
  3. Otherwise: load all fields from the inputs. valid_o <= 1 unless ctrl_i == 0; an all-zero control word is a nop and gives valid_o = 0.
- A bubble clears valid_o, so the hazard condition is gone next cycle. A load-use stall therefore lasts exactly 1 cycle; back-to-back stalls for the same pair are impossible.
- Simultaneous flush and hazard: flush wins, stall_o=0, no count.
- rd_addr_o is passed through unchanged; RegDst selection happens in EX.
- Writes to $0 (rt_addr_o==0) never cause a stall.
- Reset asserted mid-stall: the outputs clear immediately and stall_o drops in the same cycle.

Test Plan:
- Reset: assert rst_i with random inputs -> all outputs 0 while asserted and on the first edge after release, stall_cnt_o=0.
- R-type pass-through: ctrl_i=8'b0100_1110 (RegWrite, RegDst, ALUOp=11), rs_data_i=32'h1234 -> one edge later ctrl_o=8'h4E, rs_data_o=32'h1234, valid_o=1, stall_o=0.
- Load-use: lw writing rt=5 (ctrl 8'hD3) loaded, then R-type with rs_addr_i=5 -> stall_o=1 that cycle; next edge ctrl_o=0, valid_o=0, stall_cnt_o=1; following cycle stall_o=0 and the R-type loads.
- No false stall:
  - lw with rt=5, then addi (ctrl 8'h41) with rt_addr_i=5, rs_addr_i=3 -> stall_o=0.
  - lw with rt=0, then R-type with rs_addr_i=0 -> stall_o=0.
- Flush priority: load-use condition present and flush_i=1 -> stall_o=0; next edge valid_o=0, stall_cnt_o unchanged.
- Saturation: CNT_W=2, run 5 load-use pairs -> stall_cnt_o reaches 3 and stays at 3.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Holds the decoded instruction for EX, inserts a one-cycle bubble when the
// EX entry is a load whose destination feeds the incoming ID instruction,
// discards the ID instruction on a taken branch/jump, and counts bubbles.
module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        ctrl_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rs_addr_i,
    input  logic [4:0]        rt_addr_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [7:0]        ctrl_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [4:0]        rs_addr_o,
    output logic [4:0]        rt_addr_o,
    output logic [4:0]        rd_addr_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Control word bit positions.
    localparam int ALU_SRC_BIT   = 0;
    localparam int MEM_READ_BIT  = 4;
    localparam int MEM_WRITE_BIT = 5;
    localparam int REG_WRITE_BIT = 6;

    localparam logic [4:0]       REG_ZERO = 5'd0;
    localparam logic [7:0]       CTRL_NOP = 8'd0;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // rs is a real source operand whenever it names a non-zero register.
    function automatic logic rs_is_used(input logic [4:0] addr);
        return (addr != REG_ZERO);
    endfunction

    // rt is read by R-type/branch (ALUSrc=0) and as store data by sw.
    function automatic logic rt_is_used(input logic [4:0] addr, input logic [7:0] ctrl);
        return (addr != REG_ZERO) && ((ctrl[ALU_SRC_BIT] == 1'b0) || (ctrl[MEM_WRITE_BIT] == 1'b1));
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // Held EX entry.
    logic [7:0]        ctrl_r;
    logic              valid_r;
    logic [DATA_W-1:0] rs_data_r;
    logic [DATA_W-1:0] rt_data_r;
    logic [DATA_W-1:0] imm_r;
    logic [4:0]        rs_addr_r;
    logic [4:0]        rt_addr_r;
    logic [4:0]        rd_addr_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    // Hazard/priority decode.
    logic              ex_load_s;
    logic              rs_match_s;
    logic              rt_match_s;
    logic              hazard_s;
    logic              stall_s;
    logic              load_s;
    logic              count_s;
    logic [7:0]        ctrl_nxt_s;
    logic              valid_nxt_s;
    logic [CNT_W-1:0]  stall_cnt_nxt_s;

    // Detect a load in EX whose destination is read by the ID instruction.
    always_comb begin
        ex_load_s  = valid_r & ctrl_r[MEM_READ_BIT] & ctrl_r[REG_WRITE_BIT] & (rt_addr_r != REG_ZERO);
        rs_match_s = rs_is_used(rs_addr_i) & (rs_addr_i == rt_addr_r);
        rt_match_s = rt_is_used(rt_addr_i, ctrl_i) & (rt_addr_i == rt_addr_r);
        hazard_s   = ex_load_s & (rs_match_s | rt_match_s);
        stall_s    = hazard_s & ~flush_i;
    end

    // Resolve flush > bubble > load priority into next-state values.
    always_comb begin
        load_s          = 1'b0;
        count_s         = 1'b0;
        ctrl_nxt_s      = CTRL_NOP;
        valid_nxt_s     = 1'b0;
        stall_cnt_nxt_s = stall_cnt_r;
        case ({flush_i, hazard_s})
            2'b10, 2'b11: begin
                // Discarded instruction; operands hold, nothing counted.
                load_s      = 1'b0;
                count_s     = 1'b0;
                ctrl_nxt_s  = CTRL_NOP;
                valid_nxt_s = 1'b0;
            end
            2'b01: begin
                // Load-use bubble.
                load_s      = 1'b0;
                count_s     = 1'b1;
                ctrl_nxt_s  = CTRL_NOP;
                valid_nxt_s = 1'b0;
            end
            2'b00: begin
                // Normal advance; an all-zero control word is a nop.
                load_s      = 1'b1;
                count_s     = 1'b0;
                ctrl_nxt_s  = ctrl_i;
                valid_nxt_s = (ctrl_i != CTRL_NOP);
            end
            default: begin
                load_s      = 1'b0;
                count_s     = 1'b0;
                ctrl_nxt_s  = CTRL_NOP;
                valid_nxt_s = 1'b0;
            end
        endcase
        if (count_s) begin
            stall_cnt_nxt_s = sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
    end

    // Control word and valid flag: cleared on flush or bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_r  <= 8'd0;
            valid_r <= 1'b0;
        end else begin
            ctrl_r  <= ctrl_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    // Operand and index fields: captured only on a normal advance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rs_data_r <= {DATA_W{1'b0}};
            rt_data_r <= {DATA_W{1'b0}};
            imm_r     <= {DATA_W{1'b0}};
            rs_addr_r <= 5'd0;
            rt_addr_r <= 5'd0;
            rd_addr_r <= 5'd0;
        end else if (load_s) begin
            rs_data_r <= rs_data_i;
            rt_data_r <= rt_data_i;
            imm_r     <= imm_i;
            rs_addr_r <= rs_addr_i;
            rt_addr_r <= rt_addr_i;
            rd_addr_r <= rd_addr_i;
        end else begin
            rs_data_r <= rs_data_r;
            rt_data_r <= rt_data_r;
            imm_r     <= imm_r;
            rs_addr_r <= rs_addr_r;
            rt_addr_r <= rt_addr_r;
            rd_addr_r <= rd_addr_r;
        end
    end

    // Saturating count of hazard bubbles for performance debug.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    assign stall_o     = stall_s;
    assign ctrl_o      = ctrl_r;
    assign valid_o     = valid_r;
    assign rs_data_o   = rs_data_r;
    assign rt_data_o   = rt_data_r;
    assign imm_o       = imm_r;
    assign rs_addr_o   = rs_addr_r;
    assign rt_addr_o   = rt_addr_r;
    assign rd_addr_o   = rd_addr_r;
    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: a behavioural model predicts
// every edge, expected entries are queued and compared after the edge.
// A second instance with a 2-bit counter exercises saturation.
module tb_id_ex_hazard_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ctrl_in = 8'd0;
    logic [31:0] rs_data_in = 32'd0;
    logic [31:0] rt_data_in = 32'd0;
    logic [31:0] imm_in = 32'd0;
    logic [4:0]  rs_addr_in = 5'd0;
    logic [4:0]  rt_addr_in = 5'd0;
    logic [4:0]  rd_addr_in = 5'd0;
    logic        flush = 1'b0;

    logic        stall, valid, stall_b, valid_b;
    logic [7:0]  ctrl_out, ctrl_out_b;
    logic [31:0] rs_data_out, rt_data_out, imm_out;
    logic [31:0] rs_data_out_b, rt_data_out_b, imm_out_b;
    logic [4:0]  rs_addr_out, rt_addr_out, rd_addr_out;
    logic [4:0]  rs_addr_out_b, rt_addr_out_b, rd_addr_out_b;
    logic [15:0] cnt;
    logic [1:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [15:0] cnt;
        logic [1:0]  cnt_b;
    } exp_t;

    exp_t model = '0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_in),
        .rs_data_i(rs_data_in), .rt_data_i(rt_data_in), .imm_i(imm_in),
        .rs_addr_i(rs_addr_in), .rt_addr_i(rt_addr_in), .rd_addr_i(rd_addr_in),
        .flush_i(flush), .stall_o(stall), .ctrl_o(ctrl_out),
        .rs_data_o(rs_data_out), .rt_data_o(rt_data_out), .imm_o(imm_out),
        .rs_addr_o(rs_addr_out), .rt_addr_o(rt_addr_out), .rd_addr_o(rd_addr_out),
        .valid_o(valid), .stall_cnt_o(cnt)
    );

    id_ex_hazard_reg #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_in),
        .rs_data_i(rs_data_in), .rt_data_i(rt_data_in), .imm_i(imm_in),
        .rs_addr_i(rs_addr_in), .rt_addr_i(rt_addr_in), .rd_addr_i(rd_addr_in),
        .flush_i(flush), .stall_o(stall_b), .ctrl_o(ctrl_out_b),
        .rs_data_o(rs_data_out_b), .rt_data_o(rt_data_out_b), .imm_o(imm_out_b),
        .rs_addr_o(rs_addr_out_b), .rt_addr_o(rt_addr_out_b), .rd_addr_o(rd_addr_out_b),
        .valid_o(valid_b), .stall_cnt_o(cnt_b)
    );

    // Scoreboard: compare the queued prediction just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if (ctrl_out !== e.ctrl || valid !== e.valid) begin
                errors++;
                $display("FAIL sb_ctrl: got ctrl=%h valid=%b want ctrl=%h valid=%b", ctrl_out, valid, e.ctrl, e.valid);
            end
            checks++;
            if ({rs_data_out, rt_data_out, imm_out} !== {e.rs_data, e.rt_data, e.imm}) begin
                errors++;
                $display("FAIL sb_data: got %h %h %h want %h %h %h", rs_data_out, rt_data_out, imm_out, e.rs_data, e.rt_data, e.imm);
            end
            checks++;
            if ({rs_addr_out, rt_addr_out, rd_addr_out} !== {e.rs_addr, e.rt_addr, e.rd_addr}) begin
                errors++;
                $display("FAIL sb_addr: got %0d %0d %0d want %0d %0d %0d", rs_addr_out, rt_addr_out, rd_addr_out, e.rs_addr, e.rt_addr, e.rd_addr);
            end
            checks++;
            if (cnt !== e.cnt || cnt_b !== e.cnt_b || ctrl_out_b !== e.ctrl || valid_b !== e.valid) begin
                errors++;
                $display("FAIL sb_cnt: got cnt=%0d cnt_b=%0d want cnt=%0d cnt_b=%0d", cnt, cnt_b, e.cnt, e.cnt_b);
            end
        end
    end

    function automatic logic model_hazard();
        logic rs_u, rt_u;
        rs_u = (rs_addr_in != 5'd0);
        rt_u = (rt_addr_in != 5'd0) && (!ctrl_in[0] || ctrl_in[5]);
        return model.valid && model.ctrl[4] && model.ctrl[6] && (model.rt_addr != 5'd0) &&
               ((rs_u && rs_addr_in == model.rt_addr) || (rt_u && rt_addr_in == model.rt_addr));
    endfunction

    // Check stall_o, predict the edge, queue it, and advance one clock.
    task automatic cycle();
        exp_t nxt;
        logic hz;
        #1;
        hz = model_hazard();
        checks++;
        if (stall !== (hz && !flush)) begin
            errors++;
            $display("FAIL stall_pred: got %b want %b", stall, hz && !flush);
        end
        nxt = model;
        if (flush) begin
            nxt.ctrl = 8'd0;
            nxt.valid = 1'b0;
        end else if (hz) begin
            nxt.ctrl = 8'd0;
            nxt.valid = 1'b0;
            if (nxt.cnt != 16'hFFFF) nxt.cnt = nxt.cnt + 16'd1;
            if (nxt.cnt_b != 2'b11) nxt.cnt_b = nxt.cnt_b + 2'd1;
        end else begin
            nxt.ctrl = ctrl_in;
            nxt.valid = (ctrl_in != 8'd0);
            nxt.rs_data = rs_data_in;
            nxt.rt_data = rt_data_in;
            nxt.imm = imm_in;
            nxt.rs_addr = rs_addr_in;
            nxt.rt_addr = rt_addr_in;
            nxt.rd_addr = rd_addr_in;
        end
        sb_q.push_back(nxt);
        model = nxt;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [7:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d);
        ctrl_in = c;
        rs_addr_in = rs;
        rt_addr_in = rt;
        rd_addr_in = rd;
        rs_data_in = d;
        rt_data_in = d ^ 32'hFFFF_0000;
        imm_in = d + 32'd7;
    endtask

    task automatic test_reset();
        drive($urandom, $urandom, $urandom, $urandom, $urandom);
        flush = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        model = '0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if ({ctrl_out, valid, rs_data_out, rt_data_out, imm_out, rs_addr_out, rt_addr_out, rd_addr_out, cnt, stall} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs not zero ctrl=%h valid=%b cnt=%0d stall=%b", ctrl_out, valid, cnt, stall);
        end
        drive(8'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        rst = 1'b0;
        cycle();
        checks++;
        if (valid !== 1'b0 || cnt !== 16'd0 || ctrl_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: got valid=%b cnt=%0d ctrl=%h want 0 0 00", valid, cnt, ctrl_out);
        end
    endtask

    task automatic test_passthrough();
        drive(8'b0100_1110, 5'd1, 5'd2, 5'd3, 32'h1234);
        cycle();
        drive(8'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        checks++;
        if (ctrl_out !== 8'h4E || rs_data_out !== 32'h1234 || valid !== 1'b1 || stall !== 1'b0 || rd_addr_out !== 5'd3) begin
            errors++;
            $display("FAIL passthrough: got ctrl=%h rs=%h valid=%b stall=%b rd=%0d want 4e 1234 1 0 3", ctrl_out, rs_data_out, valid, stall, rd_addr_out);
        end
        cycle();
    endtask

    task automatic test_load_use();
        logic [15:0] base;
        base = model.cnt;
        drive(8'hD3, 5'd1, 5'd5, 5'd0, 32'hAAAA);
        cycle();
        drive(8'h4E, 5'd5, 5'd6, 5'd7, 32'h5555);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 1", stall);
        end
        cycle();
        checks++;
        if (ctrl_out !== 8'd0 || valid !== 1'b0 || cnt !== base + 16'd1 || stall !== 1'b0 || rt_addr_out !== 5'd5) begin
            errors++;
            $display("FAIL load_use_bubble: got ctrl=%h valid=%b cnt=%0d stall=%b want 00 0 %0d 0", ctrl_out, valid, cnt, stall, base + 16'd1);
        end
        cycle();
        checks++;
        if (ctrl_out !== 8'h4E || valid !== 1'b1 || rs_addr_out !== 5'd5) begin
            errors++;
            $display("FAIL load_use_resume: got ctrl=%h valid=%b rs=%0d want 4e 1 5", ctrl_out, valid, rs_addr_out);
        end
    endtask

    task automatic test_no_false_stall();
        drive(8'hD3, 5'd1, 5'd5, 5'd0, 32'h1111);
        cycle();
        drive(8'h41, 5'd3, 5'd5, 5'd0, 32'h2222);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL no_stall_addi: got %b want 0", stall);
        end
        cycle();
        drive(8'hD3, 5'd2, 5'd0, 5'd0, 32'h3333);
        cycle();
        drive(8'h4E, 5'd0, 5'd0, 5'd8, 32'h4444);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL no_stall_r0: got %b want 0", stall);
        end
        cycle();
        // sw reading rt as store data does stall after a load to the same register.
        drive(8'hD3, 5'd1, 5'd9, 5'd0, 32'h5151);
        cycle();
        drive(8'h21, 5'd2, 5'd9, 5'd0, 32'h6161);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL sw_rt_stall: got %b want 1", stall);
        end
        cycle();
        cycle();
    endtask

    task automatic test_flush_priority();
        logic [15:0] base;
        drive(8'hD3, 5'd1, 5'd9, 5'd0, 32'h7777);
        cycle();
        base = model.cnt;
        drive(8'h4E, 5'd9, 5'd2, 5'd4, 32'h8888);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b want 0", stall);
        end
        cycle();
        flush = 1'b0;
        checks++;
        if (valid !== 1'b0 || cnt !== base || rs_data_out !== 32'h7777) begin
            errors++;
            $display("FAIL flush_edge: got valid=%b cnt=%0d rs=%h want 0 %0d 7777", valid, cnt, rs_data_out, base);
        end
        drive(8'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            drive(8'hD3, 5'd1, 5'd4, 5'd0, 32'h100 + i);
            cycle();
            drive(8'h4E, 5'd4, 5'd4, 5'd6, 32'h200 + i);
            cycle();
            cycle();
        end
        checks++;
        if (cnt_b !== 2'd3) begin
            errors++;
            $display("FAIL saturation: got %0d want 3", cnt_b);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(8'hD3, 5'd1, 5'd5, 5'd0, 32'h9999);
        cycle();
        drive(8'h4E, 5'd5, 5'd0, 5'd1, 32'hABCD);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall_pre: got %b want 1", stall);
        end
        rst = 1'b1;
        sb_q.delete();
        model = '0;
        #1;
        checks++;
        if (stall !== 1'b0 || valid !== 1'b0 || ctrl_out !== 8'd0 || cnt !== 16'd0 || rt_addr_out !== 5'd0) begin
            errors++;
            $display("FAIL mid_stall_reset: got stall=%b valid=%b ctrl=%h cnt=%0d want all 0", stall, valid, ctrl_out, cnt);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(8'h4E, 5'd1, 5'd2, 5'd3, 32'hCAFE);
        cycle();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_back_to_back();
        test_reset_mid_stall();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
